// File: rtl/servo_pwm_array.sv
// servo_pwm_array: NUM_CH-channel servo PWM generator sharing one frame counter.
// A position set is accepted into a shadow register and applied only at the
// frame wrap, so a pulse is never truncated or stretched mid-frame.
// Optional feature: define SERVO_SLEW_LIMIT_EN to limit each channel's pulse
// change to SLEW_STEP cycles per frame (pending stays set until all channels
// reach their targets). Without it the target is loaded directly.

module servo_pwm_lane #(
  parameter int POS_W         = 10,
  parameter int CNT_W         = 21,
  parameter int PULSE_MIN_CYC = 100000,
  parameter int PULSE_MAX_CYC = 200000,
  parameter int STEP_CYC      = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [POS_W-1:0] pos,
  input  logic [CNT_W-1:0] cnt,
  input  logic             apply,
  output logic             pwm,
  output logic             at_tgt
);
  localparam logic [63:0]      SPAN   = 64'(PULSE_MAX_CYC - PULSE_MIN_CYC);
  localparam logic [CNT_W-1:0] CENTRE = CNT_W'((PULSE_MIN_CYC + PULSE_MAX_CYC) / 2);
  localparam logic [CNT_W-1:0] STEP   = CNT_W'(STEP_CYC);

  logic [63:0]      prod;
  logic [CNT_W-1:0] target;
  logic [CNT_W-1:0] active;
  logic [CNT_W-1:0] next_pulse;

  // full-width product so the largest position cannot overflow before the shift
  assign prod   = 64'(pos) * SPAN;
  assign target = CNT_W'(64'(PULSE_MIN_CYC) + (prod >> POS_W));

  // step toward the target, clamped to STEP (STEP is a full period when slew is off)
  always_comb begin
    next_pulse = target;
    if (target > active) begin
      if (target - active > STEP) next_pulse = active + STEP;
    end else if (active - target > STEP) begin
      next_pulse = active - STEP;
    end
  end

  assign at_tgt = (next_pulse == target);

  // active pulse only moves at the wrap; output compare is registered
  always_ff @(posedge clk) begin
    if (rst) begin
      active <= CENTRE;
      pwm    <= 1'b0;
    end else begin
      if (apply) active <= next_pulse;
      pwm <= (cnt < active);
    end
  end
endmodule

module servo_pwm_array #(
  parameter int NUM_CH        = 3,
  parameter int POS_W         = 10,
  parameter int PERIOD_CYC    = 2000000,
  parameter int PULSE_MIN_CYC = 100000,
  parameter int PULSE_MAX_CYC = 200000,
  parameter int SLEW_STEP     = 1000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH*POS_W-1:0] pos_in,
  input  logic                    pos_valid,
  output logic                    pos_ready,
  output logic [NUM_CH-1:0]       pwm_out,
  output logic                    frame_start
);
  localparam int CNT_W = $clog2(PERIOD_CYC);
`ifdef SERVO_SLEW_LIMIT_EN
  localparam bit SLEW_EN = 1'b1;
`else
  localparam bit SLEW_EN = 1'b0;
`endif
  // a step of PERIOD_CYC-1 exceeds any possible pulse difference, i.e. no limit
  localparam int STEP_CYC = (SLEW_EN && (SLEW_STEP < PERIOD_CYC - 1)) ? SLEW_STEP : PERIOD_CYC - 1;
  localparam logic [CNT_W-1:0] LAST     = CNT_W'(PERIOD_CYC - 1);
  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PERIOD_CYC - 2);

  typedef enum logic [1:0] {IDLE, PENDING, APPLY} state_t;

  state_t                         state, state_nxt;
  logic [CNT_W-1:0]               cnt;
  logic [NUM_CH-1:0][POS_W-1:0]   shadow;
  logic [NUM_CH-1:0]              at_tgt;
  logic                           accept;
  logic                           apply;

  assign pos_ready = ~rst & (state == IDLE);
  assign accept    = pos_valid & pos_ready;
  assign apply     = (state == APPLY);

  // free-running frame counter and frame_start aligned with pwm_out latency
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      frame_start <= 1'b0;
    end else begin
      cnt         <= (cnt == LAST) ? '0 : cnt + 1'b1;
      frame_start <= (cnt == '0);
    end
  end

  // shadow captures a whole position set atomically on accept
  always_ff @(posedge clk) begin
    if (rst)         shadow <= '0;
    else if (accept) shadow <= pos_in;
  end

  // update-sequencer state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // APPLY occupies exactly the wrap cycle; an accept in the wrap cycle waits a frame
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (cnt == PRE_LAST) ? APPLY : PENDING;
      PENDING: if (cnt == PRE_LAST) state_nxt = APPLY;
      APPLY:   state_nxt = (&at_tgt) ? IDLE : PENDING;
      default: state_nxt = IDLE;
    endcase
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    servo_pwm_lane #(
      .POS_W         (POS_W),
      .CNT_W         (CNT_W),
      .PULSE_MIN_CYC (PULSE_MIN_CYC),
      .PULSE_MAX_CYC (PULSE_MAX_CYC),
      .STEP_CYC      (STEP_CYC)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .pos    (shadow[i]),
      .cnt    (cnt),
      .apply  (apply),
      .pwm    (pwm_out[i]),
      .at_tgt (at_tgt[i])
    );
  end
endmodule
